// File: rtl/audio_clk_pkg.sv
// Shared types and helpers for the audio clock generator: frame modes,
// the runtime configuration payload and the LRCLK level decode.
package audio_clk_pkg;

    localparam int unsigned CFG_ACC_W = 32;
    localparam int unsigned CFG_DIV_W = 8;
    localparam int unsigned MODE_W    = 2;

    // 12.288 MHz MCLK from a 50 MHz refclk with a 32-bit accumulator
    localparam logic [CFG_ACC_W-1:0] DEF_PHASE_INC_12M288 = 32'd2111062325;

    typedef enum logic [MODE_W-1:0] {
        MODE_I2S = 2'd0,
        MODE_LJ  = 2'd1,
        MODE_TDM = 2'd2
    } mode_e;

    typedef struct packed {
        logic [CFG_ACC_W-1:0] phase_inc;
        logic [CFG_DIV_W-1:0] bclk_div;
        logic [MODE_W-1:0]    mode;
    } cfg_t;

    // LRCLK level at frame position p; the reserved mode falls back to I2S
    function automatic logic lr_level(input logic [MODE_W-1:0] mode,
                                      input int unsigned p,
                                      input int unsigned t,
                                      input int unsigned h);
        case (mode)
            MODE_LJ:  return p < h;
            MODE_TDM: return p == 0;
            default:  return ((p + 1) % t) >= h;
        endcase
    endfunction

endpackage

// File: rtl/audio_clock_gen_if.sv
// Configuration request channel (valid/ready) into the audio clock generator.
interface audio_clock_gen_if #(
    parameter int unsigned ACC_W = 32,
    parameter int unsigned DIV_W = 8
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [ACC_W-1:0] cfg_phase_inc;
    logic [DIV_W-1:0] cfg_bclk_div;
    logic [1:0]       cfg_mode;

    modport master (output cfg_valid, cfg_phase_inc, cfg_bclk_div, cfg_mode,
                    input  cfg_ready);
    modport slave  (input  cfg_valid, cfg_phase_inc, cfg_bclk_div, cfg_mode,
                    output cfg_ready);
endinterface

// File: rtl/audio_nco.sv
// Fractional NCO: phase accumulator whose carry-out marks an MCLK edge.
module audio_nco #(
    parameter int unsigned ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [ACC_W-1:0] phase_inc,
    output logic             carry_c
);
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W:0]   sum_c;

    assign sum_c   = {1'b0, acc_q} + {1'b0, phase_inc};
    assign carry_c = en & sum_c[ACC_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (!en) begin
            acc_q <= '0;
        end else begin
            acc_q <= sum_c[ACC_W-1:0];
        end
    end
endmodule

// File: rtl/audio_clock_gen.sv
// MCLK/BCLK/LRCLK generator for the I2S/TDM serialiser with runtime
// reconfiguration applied at frame boundaries.
module audio_clock_gen
    import audio_clk_pkg::*;
#(
    parameter int unsigned ACC_W       = CFG_ACC_W,
    parameter int unsigned SLOT_W      = 32,
    parameter int unsigned NUM_SLOTS   = 2,
    parameter int unsigned DIV_W       = CFG_DIV_W,
    parameter int unsigned LOCK_FRAMES = 4,
    parameter logic [CFG_ACC_W-1:0] DEF_PHASE_INC = DEF_PHASE_INC_12M288,
    parameter int unsigned DEF_BCLK_DIV = 4,
    parameter int unsigned DEF_MODE     = 0
) (
    input  logic refclk,
    input  logic rst_n,
    input  logic en,
    audio_clock_gen_if.slave cfg,
    output logic mclk_o,
    output logic bclk_o,
    output logic lrclk_o,
    output logic bclk_rise_stb,
    output logic bclk_fall_stb,
    output logic frame_start,
    output logic [$clog2((NUM_SLOTS > 1) ? NUM_SLOTS : 2)-1:0] slot_idx,
    output logic [$clog2(SLOT_W)-1:0] bit_idx,
    output logic locked
);
    localparam int unsigned SLOT_IW = $clog2((NUM_SLOTS > 1) ? NUM_SLOTS : 2);
    localparam int unsigned BIT_IW  = $clog2(SLOT_W);
    localparam int unsigned FRAME_T = NUM_SLOTS * SLOT_W;
    localparam int unsigned HALF_H  = (NUM_SLOTS / 2) * SLOT_W;
    localparam int unsigned LOCK_W  = $clog2(LOCK_FRAMES + 1);
    localparam int unsigned DCW     = DIV_W + 1;

    localparam cfg_t DEF_CFG = '{phase_inc: DEF_PHASE_INC,
                                 bclk_div:  CFG_DIV_W'(DEF_BCLK_DIV),
                                 mode:      MODE_W'(DEF_MODE)};

    typedef enum logic {ST_IDLE, ST_PEND} cfg_state_e;

    cfg_state_e          state_q, state_d;
    cfg_t                act_q, pend_q;
    logic                cfg_ready_q;
    logic                accept_c, apply_c;
    logic                en_q, en_start_c;
    logic                carry_c;
    logic [DIV_W-1:0]    div_cnt_q, act_div_c;
    logic                div_last_c, fall_ev_c, wrap_c;
    logic                bit_last_c, slot_last_c;
    logic [BIT_IW-1:0]   bit_nxt_c;
    logic [SLOT_IW-1:0]  slot_nxt_c;
    int unsigned         p_nxt_c;
    logic [MODE_W-1:0]   mode_eff_c;
    logic [LOCK_W-1:0]   lock_cnt_q;

    audio_nco #(.ACC_W(ACC_W)) u_nco (
        .clk       (refclk),
        .rst_n     (rst_n),
        .en        (en),
        .phase_inc (ACC_W'(act_q.phase_inc)),
        .carry_c   (carry_c)
    );

    assign cfg.cfg_ready = cfg_ready_q;
    assign en_start_c    = en & ~en_q;

    // BCLK divider and frame position look-ahead
    always_comb begin
        act_div_c   = DIV_W'(act_q.bclk_div);
        div_last_c  = (DCW'(div_cnt_q) + DCW'(1)) >= DCW'(act_div_c);
        fall_ev_c   = carry_c & div_last_c & bclk_o;
        bit_last_c  = bit_idx == BIT_IW'(SLOT_W - 1);
        slot_last_c = slot_idx == SLOT_IW'(NUM_SLOTS - 1);
        bit_nxt_c   = bit_last_c ? '0 : bit_idx + BIT_IW'(1);
        slot_nxt_c  = slot_idx;
        if (bit_last_c) begin
            slot_nxt_c = slot_last_c ? '0 : slot_idx + SLOT_IW'(1);
        end
        wrap_c  = fall_ev_c & bit_last_c & slot_last_c;
        p_nxt_c = 32'(slot_nxt_c) * SLOT_W + 32'(bit_nxt_c);
    end

    // Config handshake FSM: one pending slot, applied at a frame wrap or while idle
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        apply_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg.cfg_valid && cfg_ready_q) begin
                    accept_c = 1'b1;
                    state_d  = ST_PEND;
                end
            end
            ST_PEND: begin
                if (!en || wrap_c) begin
                    apply_c = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        mode_eff_c = apply_c ? pend_q.mode : act_q.mode;
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cfg_ready_q <= 1'b1;
            act_q       <= DEF_CFG;
            pend_q      <= '0;
            en_q        <= 1'b0;
            lock_cnt_q  <= '0;
            locked      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_ready_q <= (state_d == ST_IDLE);
            en_q        <= en;
            if (accept_c) begin
                pend_q <= '{phase_inc: CFG_ACC_W'(cfg.cfg_phase_inc),
                            bclk_div:  CFG_DIV_W'(cfg.cfg_bclk_div),
                            mode:      cfg.cfg_mode};
            end
            if (apply_c) begin
                act_q <= pend_q;
            end
            if (!en || apply_c) begin
                lock_cnt_q <= '0;
                locked     <= 1'b0;
            end else if (wrap_c && !locked) begin
                if (32'(lock_cnt_q) + 32'd1 >= LOCK_FRAMES) begin
                    locked <= 1'b1;
                end else begin
                    lock_cnt_q <= lock_cnt_q + LOCK_W'(1);
                end
            end
        end
    end

    // Clock levels, strobes and frame position
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            mclk_o        <= 1'b0;
            bclk_o        <= 1'b0;
            lrclk_o       <= 1'b0;
            bclk_rise_stb <= 1'b0;
            bclk_fall_stb <= 1'b0;
            frame_start   <= 1'b0;
            slot_idx      <= '0;
            bit_idx       <= '0;
            div_cnt_q     <= '0;
        end else if (!en) begin
            mclk_o        <= 1'b0;
            bclk_o        <= 1'b0;
            lrclk_o       <= 1'b0;
            bclk_rise_stb <= 1'b0;
            bclk_fall_stb <= 1'b0;
            frame_start   <= 1'b0;
            slot_idx      <= '0;
            bit_idx       <= '0;
            div_cnt_q     <= '0;
        end else begin
            bclk_rise_stb <= 1'b0;
            bclk_fall_stb <= 1'b0;
            frame_start   <= 1'b0;
            if (en_start_c) begin
                lrclk_o <= lr_level(act_q.mode, 32'd0, FRAME_T, HALF_H);
            end
            if (carry_c) begin
                mclk_o <= ~mclk_o;
                if (div_last_c) begin
                    div_cnt_q     <= '0;
                    bclk_o        <= ~bclk_o;
                    bclk_rise_stb <= ~bclk_o;
                    bclk_fall_stb <= bclk_o;
                end else begin
                    div_cnt_q <= div_cnt_q + DIV_W'(1);
                end
            end
            if (fall_ev_c) begin
                bit_idx     <= bit_nxt_c;
                slot_idx    <= slot_nxt_c;
                lrclk_o     <= lr_level(mode_eff_c, p_nxt_c, FRAME_T, HALF_H);
                frame_start <= wrap_c;
            end
        end
    end
endmodule
